// File: rtl/rega_wb_pkg.sv
// Shared widths, entry layout and slot arithmetic for the rega_wb writeback sequencer.
// WIDTH/RASB match the 4-entry, 8-bit register file; WBDEPTH is the write-buffer depth.
package rega_wb_pkg;

    localparam int WIDTH   = 7;
    localparam int RASB    = 1;
    localparam int WBDEPTH = 2;

    typedef logic [WIDTH:0] data_t;
    typedef logic [RASB:0]  addr_t;
    typedef logic [1:0]     count_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wb_entry_t;

    // Slots available for next-state pushes: a retiring head frees its slot this same cycle.
    function automatic count_t free_slots(input count_t count, input logic pop);
        return count_t'(WBDEPTH) - count + count_t'(pop);
    endfunction

endpackage

// File: rtl/rega_wb_if.sv
// Bundle of the ALU/load write requests, register-file write port and decode read ports.
// The sequencer takes the slave side; whoever drives the requests takes the master side.
interface rega_wb_if;
    import rega_wb_pkg::*;

    logic  alu_v;
    addr_t alu_rd;
    data_t alu_d;
    logic  alu_rdy;

    logic  ld_v;
    addr_t ld_rd;
    data_t ld_d;
    logic  ld_rdy;

    logic  we;
    addr_t wad;
    data_t wd;

    addr_t arad;
    addr_t brad;
    logic  a_busy;
    logic  b_busy;
    data_t a_fwd;
    data_t b_fwd;

    modport slave (
        input  alu_v, alu_rd, alu_d,
        output alu_rdy,
        input  ld_v, ld_rd, ld_d,
        output ld_rdy,
        output we, wad, wd,
        input  arad, brad,
        output a_busy, b_busy, a_fwd, b_fwd
    );

    modport master (
        output alu_v, alu_rd, alu_d,
        input  alu_rdy,
        output ld_v, ld_rd, ld_d,
        input  ld_rdy,
        input  we, wad, wd,
        output arad, brad,
        input  a_busy, b_busy, a_fwd, b_fwd
    );

endinterface

// File: rtl/rega_wb_match.sv
// Compares one decode read address against the buffered writes and returns busy plus
// the data of the youngest matching entry (higher index = younger).
module rega_wb_match
    import rega_wb_pkg::*;
#(
    parameter int DEPTH = WBDEPTH
) (
    input  addr_t                   rad,
    input  wb_entry_t [DEPTH-1:0]   entries,
    input  logic      [DEPTH-1:0]   valid,
    output logic                    busy,
    output data_t                   fwd
);

    // Scanning oldest to youngest lets a later match overwrite an earlier one.
    always_comb begin
        busy = 1'b0;
        fwd  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == rad)) begin
                busy = 1'b1;
                fwd  = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/rega_wb.sv
// Writeback sequencer: queues ALU and load results in a small in-order buffer, retires one
// per cycle onto the register-file write port, and exposes pending writes to decode.
module rega_wb
    import rega_wb_pkg::*;
#(
    parameter int DEPTH = WBDEPTH
) (
    input logic      clk,
    input logic      rst,
    rega_wb_if.slave bus
);

    wb_entry_t [DEPTH-1:0] entry_q;
    wb_entry_t [DEPTH-1:0] entry_d;
    count_t                count_q;
    count_t                count_d;

    logic [DEPTH-1:0] valid;
    logic             pop;
    count_t           free;
    logic             ld_rdy;
    logic             alu_rdy;
    logic             ld_acc;
    logic             alu_acc;
    int               slot;

    // Retire is suppressed while reset is asserted so nothing lands on the reset edge.
    always_comb begin
        pop     = rst && (count_q != '0);
        free    = free_slots(count_q, pop);
        ld_rdy  = (free >= 2'd1);
        alu_rdy = (free >= 2'd2) || !bus.ld_v;
        ld_acc  = bus.ld_v && ld_rdy;
        alu_acc = bus.alu_v && alu_rdy;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (int'(count_q) > i);
        end
    end

    always_comb begin
        entry_d = entry_q;
        slot    = int'(count_q) - int'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entry_d[i] = entry_q[i + 1];
            end
            entry_d[DEPTH - 1] = '0;
        end
        // Load lands first so a simultaneous ALU write becomes the younger entry.
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_acc && (slot == i)) begin
                entry_d[i] = '{addr: bus.ld_rd, data: bus.ld_d};
            end
            if (alu_acc && ((slot + int'(ld_acc)) == i)) begin
                entry_d[i] = '{addr: bus.alu_rd, data: bus.alu_d};
            end
        end
        count_d = count_q - count_t'(pop) + count_t'(ld_acc) + count_t'(alu_acc);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            entry_q <= '0;
        end else begin
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign bus.we      = pop;
    assign bus.wad     = entry_q[0].addr;
    assign bus.wd      = entry_q[0].data;
    assign bus.ld_rdy  = ld_rdy;
    assign bus.alu_rdy = alu_rdy;

    rega_wb_match #(.DEPTH(DEPTH)) u_match_a (
        .rad     (bus.arad),
        .entries (entry_q),
        .valid   (valid),
        .busy    (bus.a_busy),
        .fwd     (bus.a_fwd)
    );

    rega_wb_match #(.DEPTH(DEPTH)) u_match_b (
        .rad     (bus.brad),
        .entries (entry_q),
        .valid   (valid),
        .busy    (bus.b_busy),
        .fwd     (bus.b_fwd)
    );

endmodule

// File: tb/tb_rega_wb.sv
// Directed bench for rega_wb: reset, single/dual issue, ALU throttling, same-address
// ordering and reset with a full buffer, all against hand-computed values.
module tb_rega_wb;
    import rega_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rega_wb_if bus ();

    rega_wb #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_v = 1'b0;
        bus.ld_v  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ld(input addr_t rd, input data_t d);
        bus.ld_v  = 1'b1;
        bus.ld_rd = rd;
        bus.ld_d  = d;
    endtask

    task automatic drive_alu(input addr_t rd, input data_t d);
        bus.alu_v  = 1'b1;
        bus.alu_rd = rd;
        bus.alu_d  = d;
    endtask

    initial begin
        rst = 1'b0;
        drive_alu(2'd3, 8'hAA);
        drive_ld(2'd2, 8'hBB);
        bus.arad = 2'd3;
        bus.brad = 2'd2;

        // Reset held with both sources valid
        step();
        check("rst_we", 16'(bus.we), 16'h0);
        check("rst_a_busy", 16'(bus.a_busy), 16'h0);
        check("rst_b_busy", 16'(bus.b_busy), 16'h0);
        check("rst_a_fwd", 16'(bus.a_fwd), 16'h0);
        check("rst_wad", 16'(bus.wad), 16'h0);
        check("rst_wd", 16'(bus.wd), 16'h0);
        step();
        check("rst2_we", 16'(bus.we), 16'h0);
        check("rst2_a_busy", 16'(bus.a_busy), 16'h0);

        // Release: first acceptance at the next edge
        rst = 1'b1;
        idle();
        drive_ld(2'd1, 8'h3C);
        bus.arad = 2'd1;
        #1;
        check("rel_we", 16'(bus.we), 16'h0);
        check("rel_ld_rdy", 16'(bus.ld_rdy), 16'h1);
        check("rel_a_busy_same_cycle", 16'(bus.a_busy), 16'h0);
        step();
        idle();
        check("rel_first_we", 16'(bus.we), 16'h1);
        check("rel_first_wad", 16'(bus.wad), 16'h1);
        check("rel_first_wd", 16'(bus.wd), 16'h3C);
        check("rel_first_a_fwd", 16'(bus.a_fwd), 16'h3C);
        step();
        check("rel_drain_we", 16'(bus.we), 16'h0);

        // Single ALU write r2 <- 0x5A
        drive_alu(2'd2, 8'h5A);
        bus.arad = 2'd2;
        bus.brad = 2'd1;
        #1;
        check("alu1_rdy", 16'(bus.alu_rdy), 16'h1);
        step();
        idle();
        check("alu1_we", 16'(bus.we), 16'h1);
        check("alu1_wad", 16'(bus.wad), 16'h2);
        check("alu1_wd", 16'(bus.wd), 16'h5A);
        check("alu1_a_busy", 16'(bus.a_busy), 16'h1);
        check("alu1_a_fwd", 16'(bus.a_fwd), 16'h5A);
        check("alu1_b_busy", 16'(bus.b_busy), 16'h0);
        check("alu1_b_fwd", 16'(bus.b_fwd), 16'h0);
        step();
        check("alu1_after_we", 16'(bus.we), 16'h0);
        check("alu1_after_a_busy", 16'(bus.a_busy), 16'h0);
        check("alu1_after_a_fwd", 16'(bus.a_fwd), 16'h0);

        // Dual issue from empty: ld r1 <- 0x11, alu r3 <- 0x33
        drive_ld(2'd1, 8'h11);
        drive_alu(2'd3, 8'h33);
        bus.arad = 2'd3;
        bus.brad = 2'd1;
        #1;
        check("dual_alu_rdy", 16'(bus.alu_rdy), 16'h1);
        check("dual_ld_rdy", 16'(bus.ld_rdy), 16'h1);
        step();
        idle();
        check("dual_c1_we", 16'(bus.we), 16'h1);
        check("dual_c1_wad", 16'(bus.wad), 16'h1);
        check("dual_c1_wd", 16'(bus.wd), 16'h11);
        check("dual_c1_a_busy", 16'(bus.a_busy), 16'h1);
        check("dual_c1_a_fwd", 16'(bus.a_fwd), 16'h33);
        check("dual_c1_b_busy", 16'(bus.b_busy), 16'h1);
        check("dual_c1_b_fwd", 16'(bus.b_fwd), 16'h11);
        step();
        check("dual_c2_we", 16'(bus.we), 16'h1);
        check("dual_c2_wad", 16'(bus.wad), 16'h3);
        check("dual_c2_wd", 16'(bus.wd), 16'h33);
        check("dual_c2_b_busy", 16'(bus.b_busy), 16'h0);
        check("dual_c2_b_fwd", 16'(bus.b_fwd), 16'h0);
        step();
        check("dual_c3_we", 16'(bus.we), 16'h0);

        // Sustained dual issue; the held ALU write r3 <- 0xB2 waits for alu_rdy
        drive_ld(2'd0, 8'hA1);
        drive_alu(2'd1, 8'hB1);
        #1;
        check("sus_a_alu_rdy", 16'(bus.alu_rdy), 16'h1);
        step();
        drive_ld(2'd2, 8'hA2);
        drive_alu(2'd3, 8'hB2);
        #1;
        check("sus_b_alu_rdy", 16'(bus.alu_rdy), 16'h0);
        check("sus_b_ld_rdy", 16'(bus.ld_rdy), 16'h1);
        check("sus_b_wad", 16'(bus.wad), 16'h0);
        check("sus_b_wd", 16'(bus.wd), 16'hA1);
        step();
        drive_ld(2'd0, 8'hA3);
        #1;
        check("sus_c_alu_rdy", 16'(bus.alu_rdy), 16'h0);
        check("sus_c_wad", 16'(bus.wad), 16'h1);
        check("sus_c_wd", 16'(bus.wd), 16'hB1);
        step();
        bus.ld_v = 1'b0;
        #1;
        check("sus_d_alu_rdy", 16'(bus.alu_rdy), 16'h1);
        check("sus_d_wad", 16'(bus.wad), 16'h2);
        check("sus_d_wd", 16'(bus.wd), 16'hA2);
        step();
        idle();
        check("sus_e_we", 16'(bus.we), 16'h1);
        check("sus_e_wad", 16'(bus.wad), 16'h0);
        check("sus_e_wd", 16'(bus.wd), 16'hA3);
        step();
        check("sus_f_wad", 16'(bus.wad), 16'h3);
        check("sus_f_wd", 16'(bus.wd), 16'hB2);
        step();
        check("sus_g_we", 16'(bus.we), 16'h0);

        // Same address: ld r2 <- 0x01 (older), alu r2 <- 0x02 (younger)
        drive_ld(2'd2, 8'h01);
        drive_alu(2'd2, 8'h02);
        bus.arad = 2'd2;
        step();
        idle();
        check("same_c1_a_busy", 16'(bus.a_busy), 16'h1);
        check("same_c1_a_fwd", 16'(bus.a_fwd), 16'h02);
        check("same_c1_wad", 16'(bus.wad), 16'h2);
        check("same_c1_wd", 16'(bus.wd), 16'h01);
        step();
        check("same_c2_we", 16'(bus.we), 16'h1);
        check("same_c2_wd", 16'(bus.wd), 16'h02);
        check("same_c2_a_fwd", 16'(bus.a_fwd), 16'h02);
        step();
        check("same_c3_we", 16'(bus.we), 16'h0);
        check("same_c3_a_busy", 16'(bus.a_busy), 16'h0);

        // Reset with a full buffer: nothing buffered may reach the register file
        drive_ld(2'd1, 8'h77);
        drive_alu(2'd2, 8'h66);
        bus.arad = 2'd2;
        bus.brad = 2'd1;
        step();
        idle();
        check("mid_full_we", 16'(bus.we), 16'h1);
        check("mid_full_wd", 16'(bus.wd), 16'h77);
        rst = 1'b0;
        #1;
        check("mid_rst_edge_we", 16'(bus.we), 16'h0);
        step();
        check("mid_after_we", 16'(bus.we), 16'h0);
        check("mid_after_a_busy", 16'(bus.a_busy), 16'h0);
        check("mid_after_b_busy", 16'(bus.b_busy), 16'h0);
        check("mid_after_a_fwd", 16'(bus.a_fwd), 16'h0);
        check("mid_after_wd", 16'(bus.wd), 16'h0);
        rst = 1'b1;
        step();
        check("mid_release_we", 16'(bus.we), 16'h0);
        check("mid_release_a_busy", 16'(bus.a_busy), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rega_wb.md
# rega_wb

Writeback sequencer for the 4-entry register file. Collects result writes from the ALU and the load unit, queues them in a 2-entry in-order buffer, and retires at most one write per cycle onto the register file's single write port (`we`/`wad`/`wd`). It also exposes the pending-write state to decode through per-port busy and forwarding outputs, so readers see values not yet committed.

## Interface
Parameters:
- `DEPTH`, 2: write-buffer entries. Fixed at 2; other values are not supported.
- Data width is `` `WIDTH``+1 bits and register address width is `` `RASB``+1 bits, both from `pu.vh`.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-low; effective on a `clk` rising edge while `rst`=0.
- `alu_v` in 1: ALU result valid.
- `alu_rd` in `RASB`+1: ALU destination register.
- `alu_d` in `WIDTH`+1: ALU result data.
- `alu_rdy` out 1: ALU write accepted this cycle when `alu_v`=1.
- `ld_v` in 1: load result valid.
- `ld_rd` in `RASB`+1: load destination register.
- `ld_d` in `WIDTH`+1: load data.
- `ld_rdy` out 1: load write accepted this cycle when `ld_v`=1.
- `we` out 1: register-file write enable.
- `wad` out `RASB`+1: register-file write address.
- `wd` out `WIDTH`+1: register-file write data.
- `arad`, `brad` in `RASB`+1 each: decode read addresses; these are the same addresses presented to the register file.
- `a_busy`, `b_busy` out 1 each: a buffered write targets `arad` / `brad`.
- `a_fwd`, `b_fwd` out `WIDTH`+1 each: data of the youngest buffered write to `arad` / `brad`. Value is 0 when the matching busy output is 0.

## Operation
- The buffer is an in-order FIFO. Each entry holds {addr, data}. `count` ranges 0..2.
- **Retire:**
  - `we` = (`count`≠0); `wad`/`wd` = head entry fields.
  - The head is popped every cycle `we`=1. The register file never back-pressures.
- **Free slots for the next state:** `free` = 2 − `count` + `we`. This gives 2 at count 0 or 1, and 1 at count 2.
- **Acceptance priority:** the load unit has priority because memory cannot stall.
  - `ld_rdy` = (`free` ≥ 1). This is always 1 under these rules; it is kept as a port for future depths.
  - `alu_rdy` = (`free` ≥ 2) | !`ld_v`.
- **Simultaneous accept:** the load entry is enqueued first, then the ALU entry. Program order between the two units is decided upstream; the buffer only preserves arrival order.
- **Count update:** next `count` = `count` − `we` + accepted pushes. It never exceeds 2.
- **Busy/forward:**
  - These are combinational over the buffered entries only. Inputs presented in the same cycle are not visible until they are enqueued.
  - When both entries match an address, the tail (younger) entry wins.
- **Same-address writes:** entries are never merged. Both entries retire, in order.
- **Register 0:** not special; it is written like any other register.
- **Reset** (`rst`=0 at an edge):
  - `count`=0, `we`=0, all entry fields 0, busy outputs 0, forwarding outputs 0.
  - Writes in flight are discarded, and nothing reaches the register file on the reset edge.
  - Inputs are ignored during that cycle.

## Timing
- **Latency:** a write accepted at edge N into an empty buffer drives `we`=1 during the cycle after edge N. It lands in the register file at edge N+1.
- **Throughput:** one retire per cycle. Sustained dual-source input throttles the ALU through `alu_rdy`.
- `alu_rdy`, `ld_rdy`, busy and forwarding outputs depend combinationally on `count`/state and `ld_v`. There is no combinational path from `alu_v` to any output.
- **Hazard window:** a value written into the register file at edge N is readable directly from the register file in cycle N+1. It is busy/forwarded up to and including cycle N.

## Structure
- No new package. `WIDTH` and `RASB` come from `pu.vh`, and `DEPTH` is added there as `WBDEPTH`.
- One natural sub-module, `rega_wb_match`. It compares one read address against the 2 entries and returns busy plus youngest-match data. It is instantiated twice, for ports a and b.

## Test plan
- **Reset:** hold `rst`=0 with `alu_v`=`ld_v`=1 → `we`=0, `a_busy`=0; after release, first acceptance occurs next edge.
- **Single ALU write:** ALU write r2←0x5A at edge 1 → `we`=1, `wad`=2, `wd`=0x5A in cycle 1. `a_busy`=1 with `a_fwd`=0x5A when `arad`=2 in cycle 1; 0 in cycle 2.
- **Dual issue from empty:** `ld` r1←0x11 and ALU r3←0x33 in the same cycle → both accepted. Retire r1 then r3 on consecutive cycles.
- **Sustained dual issue for 3 cycles:** second cycle has `alu_rdy`=0 (count 2); no entry lost. Retire order matches acceptance order.
- **Same address:** r2←0x01 then r2←0x02 buffered → `a_fwd`=0x02 while both are present. Both writes reach the register file in order.
- **Reset mid-operation:** assert reset with `count`=2 → the next cycle has `we`=0, and the buffered values never reach the register file.
